// File: rtl/serial_sum_decoder.sv
// Bit-serial inverse of the constant-offset adder: a = sum - b - K (mod 2^WIDTH), one DIGIT_W digit per clock.
// Optional feature macro: SERIAL_SUM_DECODER_CONST_EN (defined: subtract K; undefined: a = sum - b).
module serial_sum_decoder #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned DIGIT_W = 8,
  parameter logic [63:0] K       = 64'hDEADBEEFDEADC6BF
) (
  input  logic             IN_clk,
  input  logic             IN_rst,
  input  logic             IN_valid,
  output logic             OUT_ready,
  input  logic [WIDTH-1:0] IN_sum,
  input  logic [WIDTH-1:0] IN_b,
  output logic             OUT_valid,
  input  logic             IN_ready,
  output logic [WIDTH-1:0] OUT_a,
  output logic             OUT_borrow
);

  localparam int unsigned N     = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
`ifdef SERIAL_SUM_DECODER_CONST_EN
  localparam int unsigned BW = 2;
`else
  localparam int unsigned BW = 1;
`endif
  localparam int unsigned DW = DIGIT_W + BW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   sum_sr, b_sr, res_sr, res_next, a_q;
`ifdef SERIAL_SUM_DECODER_CONST_EN
  logic [WIDTH-1:0]   k_sr;
`endif
  logic [CNT_W-1:0]   cnt;
  logic [BW-1:0]      borrow, borrow_next;
  logic [DW-1:0]      d;
  logic [DIGIT_W-1:0] dig;
  logic               borrow_q;
  logic               accept, last_dig;

  assign accept   = (state == IDLE) && IN_valid;
  assign last_dig = (state == RUN) && (cnt == CNT_W'(N - 1));

  // The digit difference wraps modulo 2^DW; its top BW bits are the signed
  // floor quotient (0, -1 or -2), so negating them yields the borrow.
  always_comb begin
    d = DW'(sum_sr[DIGIT_W-1:0]) - DW'(b_sr[DIGIT_W-1:0]) - DW'(borrow);
`ifdef SERIAL_SUM_DECODER_CONST_EN
    d = d - DW'(k_sr[DIGIT_W-1:0]);
`endif
    dig         = d[DIGIT_W-1:0];
    borrow_next = ~d[DW-1:DIGIT_W] + BW'(1);
    res_next    = (res_sr >> DIGIT_W) | (WIDTH'(dig) << (WIDTH - DIGIT_W));
  end

  always_ff @(posedge IN_clk) begin
    if (IN_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (IN_valid) state_next = RUN;
      RUN:     if (last_dig) state_next = DONE;
      DONE:    if (IN_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    OUT_ready = (state == IDLE);
    OUT_valid = (state == DONE);
  end

  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      sum_sr   <= '0;
      b_sr     <= '0;
`ifdef SERIAL_SUM_DECODER_CONST_EN
      k_sr     <= '0;
`endif
      res_sr   <= '0;
      cnt      <= '0;
      borrow   <= '0;
      a_q      <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      sum_sr <= IN_sum;
      b_sr   <= IN_b;
`ifdef SERIAL_SUM_DECODER_CONST_EN
      k_sr   <= WIDTH'(K);
`endif
      cnt    <= '0;
      borrow <= '0;
    end else if (state == RUN) begin
      sum_sr <= sum_sr >> DIGIT_W;
      b_sr   <= b_sr >> DIGIT_W;
`ifdef SERIAL_SUM_DECODER_CONST_EN
      k_sr   <= k_sr >> DIGIT_W;
`endif
      res_sr <= res_next;
      borrow <= borrow_next;
      cnt    <= cnt + CNT_W'(1);
      // Result registers only change on the final digit so they hold outside DONE.
      if (last_dig) begin
        a_q      <= res_next;
        borrow_q <= |borrow_next;
      end
    end
  end

  assign OUT_a      = a_q;
  assign OUT_borrow = borrow_q;

endmodule
